// File: rtl/mem_responder.sv
// Memory-side responder for the 65C02 bus: zero-wait internal RAM mirrored over the
// low 32 KiB, plus a req/ack external port for the upper half with RDY stall and timeout.
module mem_responder #(
  parameter int unsigned RAM_AW  = 11,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DB,
  output logic        RDY,
  output logic        ext_req,
  output logic        ext_we,
  output logic [14:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        err,
  input  logic        err_clr
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXT  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_db;
  logic             r_rdy;
  logic             r_ext_req;
  logic             r_ext_we;
  logic [14:0]      r_ext_addr;
  logic [7:0]       r_ext_wdata;
  logic             r_err;
  logic [7:0]       r_ram [RAM_DEPTH];

  logic              w_accept;
  logic              w_ext_start;
  logic              w_int_rd;
  logic              w_int_wr;
  logic              w_ack;
  logic              w_timeout;
  logic [RAM_AW-1:0] w_idx;

  assign w_idx = AB[RAM_AW-1:0];

  // Next-state and transaction-event decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ext_start = 1'b0;
    w_int_rd    = 1'b0;
    w_int_wr    = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = r_rdy && !RST;
        if (w_accept) begin
          if (AB[15]) begin
            w_ext_start = 1'b1;
            w_state_nxt = ST_EXT;
          end else begin
            w_int_rd = !WE;
            w_int_wr = WE;
          end
        end
      end
      ST_EXT: begin
        // ack beats a coincident timeout
        if (ext_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // RAM has no reset; contents survive RST
  always_ff @(posedge clk) begin
    if (w_int_wr) r_ram[w_idx] <= DO;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_db        <= 8'h00;
      r_rdy       <= 1'b1;
      r_ext_req   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_addr  <= 15'h0000;
      r_ext_wdata <= 8'h00;
      r_cnt       <= '0;
    end else begin
      if (w_int_rd) r_db <= r_ram[w_idx];

      if (w_ext_start) begin
        r_ext_addr  <= AB[14:0];
        r_ext_we    <= WE;
        r_ext_wdata <= DO;
        r_ext_req   <= 1'b1;
        r_rdy       <= 1'b0;
        r_cnt       <= CNT_LOAD;
      end

      if (w_ack) begin
        if (!r_ext_we) r_db <= ext_rdata;
        r_ext_req <= 1'b0;
        r_rdy     <= 1'b1;
      end else if (w_timeout) begin
        if (!r_ext_we) r_db <= 8'hFF;
        r_ext_req <= 1'b0;
        r_rdy     <= 1'b1;
      end else if (r_state == ST_EXT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Sticky error: a timeout outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (RST)            r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

  assign DB        = r_db;
  assign RDY       = r_rdy;
  assign ext_req   = r_ext_req;
  assign ext_we    = r_ext_we;
  assign ext_addr  = r_ext_addr;
  assign ext_wdata = r_ext_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// compared against a transaction-level model (byte array + expected DB/err).
module tb_mem_responder;

  localparam int unsigned RAM_AW  = 11;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DEPTH   = 1 << RAM_AW;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic [7:0]  DB;
  logic        RDY;
  logic        ext_req;
  logic        ext_we;
  logic [14:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic        err;
  logic        err_clr;

  mem_responder #(.RAM_AW(RAM_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .RST(RST), .AB(AB), .WE(WE), .DO(DO), .DB(DB), .RDY(RDY),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_m [DEPTH];
  int         written [$];
  logic [7:0] exp_db;
  logic       err_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One zero-wait internal write; DB must hold its previous value
  task automatic int_write(input logic [15:0] a, input logic [7:0] d);
    int idx;
    AB = a & 16'h7FFF; WE = 1'b1; DO = d;
    ext_ack = 1'($urandom); ext_rdata = 8'($urandom);
    tick();
    ext_ack = 1'b0;
    idx = int'(a & 16'h7FFF) % DEPTH;
    mem_m[idx] = d;
    written.push_back(idx);
    chk("wr_rdy", RDY, 1);
    chk("wr_db_hold", DB, exp_db);
    chk("wr_no_req", ext_req, 0);
  endtask

  // One zero-wait internal read, optionally pulsing err_clr in the same cycle
  task automatic int_read(input logic [15:0] a, input logic clr);
    AB = a & 16'h7FFF; WE = 1'b0; DO = 8'($urandom); err_clr = clr;
    ext_ack = 1'($urandom); ext_rdata = 8'($urandom);
    tick();
    ext_ack = 1'b0; err_clr = 1'b0;
    exp_db = mem_m[int'(a & 16'h7FFF) % DEPTH];
    if (clr) err_m = 1'b0;
    chk("rd_db", DB, exp_db);
    chk("rd_rdy", RDY, 1);
    chk("rd_err", err, err_m);
  endtask

  // External access; ack_c = cycle of ext_req carrying the ack (0 = never)
  task automatic ext_acc(input logic [15:0] a, input logic w, input logic [7:0] wd,
                         input int ack_c, input logic [7:0] rd, input logic clr_last);
    logic done;
    logic acked;
    AB = a | 16'h8000; WE = w; DO = wd;
    tick();
    done = 1'b0;
    for (int c = 1; c <= int'(TIMEOUT) && !done; c++) begin
      chk("ext_req_hi", ext_req, 1);
      chk("ext_rdy_lo", RDY, 0);
      chk("ext_addr", ext_addr, a & 16'h7FFF);
      chk("ext_we", ext_we, w);
      chk("ext_wdata", ext_wdata, wd);
      AB = 16'($urandom); WE = 1'($urandom); DO = 8'($urandom);
      if (c == ack_c) begin
        ext_ack = 1'b1; ext_rdata = rd; done = 1'b1;
      end
      if (c == int'(TIMEOUT) && clr_last) err_clr = 1'b1;
      tick();
      ext_ack = 1'b0; err_clr = 1'b0; ext_rdata = 8'($urandom);
    end
    acked = (ack_c >= 1 && ack_c <= int'(TIMEOUT));
    if (acked) begin
      if (!w) exp_db = rd;
      if (clr_last && ack_c == int'(TIMEOUT)) err_m = 1'b0;
    end else begin
      if (!w) exp_db = 8'hFF;
      err_m = 1'b1;
    end
    chk("ext_done_rdy", RDY, 1);
    chk("ext_done_req", ext_req, 0);
    chk("ext_done_db", DB, exp_db);
    chk("ext_done_err", err, err_m);
  endtask

  initial begin
    RST = 1'b1; AB = 16'h0000; WE = 1'b0; DO = 8'h00;
    ext_rdata = 8'h00; ext_ack = 1'b0; err_clr = 1'b0;
    exp_db = 8'h00; err_m = 1'b0;
    tick(); tick();
    chk("rst_db", DB, 8'h00);
    chk("rst_rdy", RDY, 1);
    chk("rst_req", ext_req, 0);
    chk("rst_we", ext_we, 0);
    chk("rst_addr", ext_addr, 0);
    chk("rst_wdata", ext_wdata, 0);
    chk("rst_err", err, 0);
    RST = 1'b0;

    // write then immediate read-back
    int_write(16'h0123, 8'hA5);
    int_read(16'h0123, 1'b0);

    // mirror across the 2 KiB RAM
    int_write(16'h0801, 8'h3C);
    int_read(16'h0001, 1'b0);

    // external read acked in the 3rd request cycle
    ext_acc(16'h8042, 1'b0, 8'h00, 3, 8'h77, 1'b0);

    // external write that times out, then clear err
    ext_acc(16'hC000, 1'b1, 8'h5A, 0, 8'h00, 1'b0);
    int_read(16'h0123, 1'b1);

    // ack coincident with the last counter value wins over the timeout
    ext_acc(16'h9234, 1'b0, 8'h00, int'(TIMEOUT), 8'h12, 1'b0);
    // timeout coincident with err_clr leaves err set
    ext_acc(16'hA000, 1'b0, 8'h00, 0, 8'h00, 1'b1);
    int_read(16'h0801, 1'b1);

    // back-to-back externals
    ext_acc(16'h8001, 1'b0, 8'h00, 1, 8'hC3, 1'b0);
    ext_acc(16'h8002, 1'b1, 8'h44, 1, 8'h00, 1'b0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      if (kind <= 1 || written.size() == 0) begin
        int_write(16'($urandom), 8'($urandom));
      end else if (kind <= 3) begin
        int_read(16'(written[$urandom_range(0, written.size() - 1)]), 1'($urandom_range(0, 3) == 0));
      end else begin
        ext_acc(16'($urandom), 1'($urandom), 8'($urandom),
                int'($urandom_range(0, TIMEOUT)), 8'($urandom), 1'($urandom));
      end
    end

    // reset in the middle of an external access; a late ack is ignored
    AB = 16'h8042; WE = 1'b0; DO = 8'h00;
    tick();
    chk("mid_req", ext_req, 1);
    RST = 1'b1;
    tick();
    exp_db = 8'h00; err_m = 1'b0;
    chk("mid_rst_req", ext_req, 0);
    chk("mid_rst_rdy", RDY, 1);
    chk("mid_rst_db", DB, 8'h00);
    RST = 1'b0;
    AB = 16'h0123; WE = 1'b1; DO = 8'hEE;
    ext_ack = 1'b1; ext_rdata = 8'h99;
    tick();
    ext_ack = 1'b0;
    mem_m[16'h0123 % DEPTH] = 8'hEE;
    chk("late_ack_db", DB, 8'h00);
    chk("late_ack_req", ext_req, 0);
    chk("late_ack_rdy", RDY, 1);
    // RAM keeps contents across reset
    int_read(16'h0801, 1'b0);
    int_read(16'h0123, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
